// File: rtl/io_pkg.sv
// io_pkg: shared device IDs, command codes, FSM state and request layout for io_dispatch.
//   DEV_LEDS / DEV_SELF : device IDs for the LED block and the dispatcher itself
//   CMD_*               : bus command codes (CMD_NOP is ignored by every peripheral)
//   state_e             : sequencer states
//   req_t               : one queued CPU I/O request
package io_pkg;
   localparam logic [4:0] DEV_LEDS  = 5'd0;
   localparam logic [4:0] DEV_SELF  = 5'd31;
   localparam logic [5:0] CMD_NOP   = 6'd0;
   localparam logic [5:0] CMD_WRITE = 6'd1;
   localparam logic [5:0] CMD_READ  = 6'd2;
   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RD_WAIT, S_RESP} state_e;
   typedef struct packed {
      logic [4:0]  dev;
      logic [5:0]  cmd;
      logic [31:0] wdata;
      logic        rd;
   } req_t;
   localparam int REQ_W = $bits(req_t);
endpackage

// File: rtl/io_dispatch_if.sv
// io_dispatch_if: CPU request/response handshake plus the shared peripheral bus.
//   req_*      : CPU request (valid/ready), device, command, payload, read flag
//   bus_*      : registered broadcast beat and muxed peripheral read data
//   rsp_*      : read response (valid/ready) and data
//   busy       : dispatcher has queued or in-flight work
//   master     : CPU / peripheral side;  slave : dispatcher side
interface io_dispatch_if;
   logic        req_valid;
   logic        req_ready;
   logic [4:0]  req_dev;
   logic [5:0]  req_cmd;
   logic [31:0] req_wdata;
   logic        req_rd;
   logic [4:0]  bus_device;
   logic [5:0]  bus_command;
   logic [31:0] bus_data;
   logic [31:0] bus_rdata;
   logic        rsp_valid;
   logic [31:0] rsp_data;
   logic        rsp_ready;
   logic        busy;
   modport master (
      output req_valid, req_dev, req_cmd, req_wdata, req_rd, bus_rdata, rsp_ready,
      input  req_ready, bus_device, bus_command, bus_data, rsp_valid, rsp_data, busy
   );
   modport slave (
      input  req_valid, req_dev, req_cmd, req_wdata, req_rd, bus_rdata, rsp_ready,
      output req_ready, bus_device, bus_command, bus_data, rsp_valid, rsp_data, busy
   );
endinterface

// File: rtl/io_req_fifo.sv
// io_req_fifo: synchronous FIFO with full/empty flags, flushed by asynchronous reset.
//   clk, reset : clock, async active-high flush
//   i_push     : write i_wdata (ignored when full)
//   i_pop      : advance read pointer (ignored when empty)
//   o_rdata    : head entry, valid while !o_empty
//   o_full     : no space; o_empty : nothing stored
module io_req_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_full,
   output logic             o_empty
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wptr;
   logic [AW:0]      r_rptr;
   logic             w_push;
   logic             w_pop;
   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign o_empty = r_wptr == r_rptr;
   assign o_full  = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) & (r_wptr[AW] != r_rptr[AW]);
   assign w_push  = i_push & !o_full;
   assign w_pop   = i_pop & !o_empty;
   assign o_rdata = r_mem[r_rptr[AW-1:0]];
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         r_wptr <= w_push ? r_wptr + (AW+1)'(1) : r_wptr;
         r_rptr <= w_pop ? r_rptr + (AW+1)'(1) : r_rptr;
      end
   end
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
   end
endmodule

// File: rtl/io_dispatch.sv
// io_dispatch: in-order I/O command sequencer from the CPU request port to the peripheral bus.
//   clk, reset : clock, asynchronous active-high reset
//   io (slave) : request handshake, broadcast bus beat, bus read data, read response, busy
//   FIFO_DEPTH : request FIFO entries (power of two, >= 2)
//   RD_LATENCY : cycles from read issue to valid bus_rdata (1..3)
// Optional feature macro IO_DISPATCH_PERF_EN: a 32-bit count of non-NOP bus beats that is
// read (read of device 31) and cleared (write to device 31) internally without a bus beat.
module io_dispatch import io_pkg::*; #(
   parameter int FIFO_DEPTH = 4,
   parameter int RD_LATENCY = 1
) (
   input logic        clk,
   input logic        reset,
   io_dispatch_if.slave io
);
   state_e      r_state;
   state_e      w_nxt;
   state_e      w_pop_st;
   req_t        w_in;
   req_t        w_head;
   logic        w_full;
   logic        w_empty;
   logic        w_pop;
   logic        w_self;
   logic        w_self_rd;
   logic        w_drive;
   logic        w_sample;
   logic [31:0] w_rsp_nxt;
   logic [4:0]  r_dev;
   logic [5:0]  r_cmd;
   logic [31:0] r_data;
   logic        r_rd;
   logic [1:0]  r_wait;
   logic [31:0] r_rsp;

   assign w_in = '{dev: io.req_dev, cmd: io.req_cmd, wdata: io.req_wdata, rd: io.req_rd};

   io_req_fifo #(.WIDTH(REQ_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (io.req_valid),
      .i_wdata (w_in),
      .i_pop   (w_pop),
      .o_rdata (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // A pop happens whenever the bus is free to take the next entry: from IDLE, right
   // behind a write beat, or in the cycle a held response is consumed.
   assign w_pop = !w_empty & ((r_state == S_IDLE) | ((r_state == S_ISSUE) & !r_rd) |
                              ((r_state == S_RESP) & io.rsp_ready));
   assign w_self_rd = w_self & w_head.rd;
   // Internal reads skip the bus entirely; internal writes leave a NOP bubble in ISSUE.
   assign w_pop_st  = w_self_rd ? S_RESP : S_ISSUE;
   assign w_drive   = w_pop & !w_self;
   assign w_sample  = (r_state == S_RD_WAIT) & (r_wait == '0);

`ifdef IO_DISPATCH_PERF_EN
   logic [31:0] r_perf;
   logic [31:0] w_perf_now;
   assign w_self = w_head.dev == DEV_SELF;
   // Includes the beat on the bus this cycle so a read sees every earlier beat.
   assign w_perf_now = r_perf + {31'd0, r_cmd != CMD_NOP};
   assign w_rsp_nxt  = (w_pop & w_self_rd) ? w_perf_now : w_sample ? io.bus_rdata : r_rsp;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_perf <= '0;
      else r_perf <= (w_pop & w_self & !w_head.rd) ? '0 : w_perf_now;
   end
`else
   assign w_self    = 1'b0;
   assign w_rsp_nxt = w_sample ? io.bus_rdata : r_rsp;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else r_state <= w_nxt;
   end

   always_comb begin
      w_nxt = r_state;
      case (r_state)
         S_IDLE:    w_nxt = w_pop ? w_pop_st : S_IDLE;
         S_ISSUE:   w_nxt = r_rd ? S_RD_WAIT : w_pop ? w_pop_st : S_IDLE;
         S_RD_WAIT: w_nxt = w_sample ? S_RESP : S_RD_WAIT;
         S_RESP:    w_nxt = !io.rsp_ready ? S_RESP : w_pop ? w_pop_st : S_IDLE;
         default:   w_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      io.req_ready   = !w_full;
      io.rsp_valid   = r_state == S_RESP;
      io.rsp_data    = r_rsp;
      io.busy        = !w_empty | (r_state != S_IDLE);
      io.bus_device  = r_dev;
      io.bus_command = r_cmd;
      io.bus_data    = r_data;
   end

   // Bus registers carry a popped entry for exactly one cycle and the idle beat otherwise.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_dev  <= DEV_SELF;
         r_cmd  <= CMD_NOP;
         r_data <= '0;
         r_rd   <= 1'b0;
         r_wait <= '0;
         r_rsp  <= '0;
      end else begin
         r_dev  <= w_drive ? w_head.dev : DEV_SELF;
         r_cmd  <= w_drive ? w_head.cmd : CMD_NOP;
         r_data <= w_drive ? w_head.wdata : '0;
         r_rd   <= w_drive & w_head.rd;
         r_wait <= (r_state == S_ISSUE) ? 2'(RD_LATENCY - 1) : r_wait - 2'd1;
         r_rsp  <= w_rsp_nxt;
      end
   end
endmodule

// File: tb/tb_io_dispatch.sv
// tb_io_dispatch: directed self-checking bench for io_dispatch (FIFO_DEPTH=4, RD_LATENCY=2).
module tb_io_dispatch;
   import io_pkg::*;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;
   int   cnt;
   int   pushed;

   io_dispatch_if io ();
   io_dispatch #(.FIFO_DEPTH(4), .RD_LATENCY(2)) dut (.clk(clk), .reset(reset), .io(io));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_bus(input string tag, input logic [4:0] d, input logic [5:0] c, input logic [31:0] x);
      chk({tag, ".dev"}, 32'(io.bus_device), 32'(d));
      chk({tag, ".cmd"}, 32'(io.bus_command), 32'(c));
      chk({tag, ".data"}, io.bus_data, x);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [4:0] d, input logic [5:0] c, input logic [31:0] x, input logic r);
      io.req_valid = v;
      io.req_dev   = d;
      io.req_cmd   = c;
      io.req_wdata = x;
      io.req_rd    = r;
   endtask

`ifdef IO_DISPATCH_PERF_EN
   task automatic push(input logic [4:0] d, input logic [5:0] c, input logic [31:0] x, input logic r);
      int t = 0;
      drive(1'b1, d, c, x, r);
      while (!io.req_ready && t < 50) begin
         tick;
         t++;
      end
      chk("push.ready", 32'(io.req_ready), 32'd1);
      tick;
      io.req_valid = 1'b0;
   endtask

   task automatic wait_rsp(input string tag, input logic [31:0] exp);
      int t = 0;
      while (!io.rsp_valid && t < 50) begin
         tick;
         t++;
      end
      chk({tag, ".valid"}, 32'(io.rsp_valid), 32'd1);
      chk({tag, ".data"}, io.rsp_data, exp);
      chk_bus({tag, ".bus"}, DEV_SELF, CMD_NOP, 32'd0);
      io.rsp_ready = 1'b1;
      tick;
      io.rsp_ready = 1'b0;
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      drive(1'b0, 5'd0, CMD_NOP, 32'd0, 1'b0);
      io.rsp_ready = 1'b0;
      io.bus_rdata = 32'h1111_1111;
      tick;
      tick;
      reset = 1'b0;
      chk("rst.ready", 32'(io.req_ready), 32'd1);
      chk("rst.busy", 32'(io.busy), 32'd0);
      chk("rst.rsp_valid", 32'(io.rsp_valid), 32'd0);
      chk("rst.rsp_data", io.rsp_data, 32'd0);
      chk_bus("rst.bus", DEV_SELF, CMD_NOP, 32'd0);

      // Single write: beat appears two edges after acceptance, for one cycle.
      drive(1'b1, DEV_LEDS, CMD_WRITE, 32'hA5, 1'b0);
      tick;
      io.req_valid = 1'b0;
      chk_bus("wr1.pre", DEV_SELF, CMD_NOP, 32'd0);
      tick;
      chk_bus("wr1.beat", DEV_LEDS, CMD_WRITE, 32'hA5);
      tick;
      chk_bus("wr1.post", DEV_SELF, CMD_NOP, 32'd0);
      chk("wr1.busy", 32'(io.busy), 32'd0);

      // Five back-to-back writes with the bus draining one per cycle.
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 5'(i), CMD_WRITE, 32'h10 + i, 1'b0);
         tick;
         chk("b2b.ready", 32'(io.req_ready), 32'd1);
         if (i >= 1) chk_bus("b2b.beat", 5'(i - 1), CMD_WRITE, 32'h10 + i - 1);
      end
      io.req_valid = 1'b0;
      tick;
      chk_bus("b2b.last", 5'd4, CMD_WRITE, 32'h14);
      tick;
      chk_bus("b2b.idle", DEV_SELF, CMD_NOP, 32'd0);

      // Read with RD_LATENCY=2 and a write queued behind it.
      drive(1'b1, 5'd3, CMD_READ, 32'd0, 1'b1);
      tick;
      drive(1'b1, 5'd4, CMD_WRITE, 32'h77, 1'b0);
      tick;
      io.req_valid = 1'b0;
      chk_bus("rd.beat", 5'd3, CMD_READ, 32'd0);
      tick;
      chk_bus("rd.wait1", DEV_SELF, CMD_NOP, 32'd0);
      tick;
      chk("rd.wait2.valid", 32'(io.rsp_valid), 32'd0);
      io.bus_rdata = 32'hDEAD_BEEF;
      tick;
      io.bus_rdata = 32'h2222_2222;
      chk("rd.rsp.valid", 32'(io.rsp_valid), 32'd1);

      // Hold the response for 10 cycles while the FIFO fills behind it.
      cnt = 1;
      pushed = 0;
      for (int j = 0; j < 10; j++) begin
         chk("hold.valid", 32'(io.rsp_valid), 32'd1);
         chk("hold.data", io.rsp_data, 32'hDEAD_BEEF);
         chk_bus("hold.bus", DEV_SELF, CMD_NOP, 32'd0);
         chk("hold.ready", 32'(io.req_ready), 32'(cnt < 4));
         drive(1'b1, 5'd1, CMD_WRITE, 32'h100 + pushed, 1'b0);
         tick;
         if (cnt < 4) begin
            cnt++;
            pushed++;
         end
      end
      chk("full.ready", 32'(io.req_ready), 32'd0);
      io.rsp_ready = 1'b1;
      tick;
      io.rsp_ready = 1'b0;
      chk("cons.valid", 32'(io.rsp_valid), 32'd0);
      chk_bus("cons.beat", 5'd4, CMD_WRITE, 32'h77);
      chk("cons.ready", 32'(io.req_ready), 32'd1);
      tick;
      io.req_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk_bus("drain.beat", 5'd1, CMD_WRITE, 32'h100 + k);
         tick;
      end
      chk_bus("drain.idle", DEV_SELF, CMD_NOP, 32'd0);
      chk("drain.busy", 32'(io.busy), 32'd0);

      // Reset in the middle of RD_WAIT drops the read.
      drive(1'b1, 5'd2, CMD_READ, 32'd0, 1'b1);
      tick;
      io.req_valid = 1'b0;
      tick;
      chk_bus("rrst.beat", 5'd2, CMD_READ, 32'd0);
      tick;
      #2 reset = 1'b1;
      #1;
      chk_bus("rrst.bus", DEV_SELF, CMD_NOP, 32'd0);
      chk("rrst.busy", 32'(io.busy), 32'd0);
      chk("rrst.rsp_valid", 32'(io.rsp_valid), 32'd0);
      chk("rrst.rsp_data", io.rsp_data, 32'd0);
      tick;
      tick;
      reset = 1'b0;
      chk("rrst.ready", 32'(io.req_ready), 32'd1);
      for (int k = 0; k < 4; k++) begin
         tick;
         chk("rrst.norsp", 32'(io.rsp_valid), 32'd0);
      end
      drive(1'b1, 5'd5, CMD_WRITE, 32'hCAFE, 1'b0);
      tick;
      io.req_valid = 1'b0;
      chk_bus("post.pre", DEV_SELF, CMD_NOP, 32'd0);
      tick;
      chk_bus("post.beat", 5'd5, CMD_WRITE, 32'hCAFE);
      tick;
      chk_bus("post.idle", DEV_SELF, CMD_NOP, 32'd0);

`ifdef IO_DISPATCH_PERF_EN
      push(DEV_SELF, CMD_WRITE, 32'd0, 1'b0);
      for (int k = 0; k < 3; k++) push(DEV_LEDS, CMD_WRITE, 32'h1 + k, 1'b0);
      push(DEV_SELF, CMD_READ, 32'd0, 1'b1);
      wait_rsp("perf3", 32'd3);
      push(DEV_SELF, CMD_WRITE, 32'd0, 1'b0);
      push(DEV_SELF, CMD_READ, 32'd0, 1'b1);
      wait_rsp("perf0", 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
